// File: rtl/mem_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump_pkg
//  Description : Shared types and helpers for the memory dump engine.
//                Defines the FSM state encoding, the ASCII separator
//                characters, and a nibble-to-uppercase-hex converter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_dump_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAT    = 3'd2,
        EMIT   = 3'd3,
        ARM    = 3'd4,
        TXWAIT = 3'd5,
        FIN    = 3'd6
    } dump_state_t;

    localparam logic [7:0] CHR_SP = 8'h20;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;

    // '0'..'9' = 0x30..0x39, 'A'..'F' = 0x41..0x46
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage : mem_dump_pkg
`default_nettype wire

// File: rtl/mem_dump_hex_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : hex_fmt
//  Description : Combinational character selector for hex-mode dumps.
//                For one data byte the character sequence is
//                  idx0 : high nibble in ASCII hex
//                  idx1 : low nibble in ASCII hex
//                  idx2 : space (last) or CR when eol is set
//                  idx3 : LF (last, only reached when eol is set)
//  Ports       : data     - byte being formatted
//                char_idx - position within the sequence (0..3)
//                eol      - byte closes a line (line full or final byte)
//                char_out - character for this position
//                last     - char_out is the final character for this byte
//  Revision    : 1.0  initial release
// ============================================================================
module hex_fmt
    import mem_dump_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] char_idx,
    input  logic       eol,
    output logic [7:0] char_out,
    output logic       last
);

    always_comb begin
        char_out = CHR_SP;
        last     = 1'b0;
        case (char_idx)
            2'd0: char_out = nibble_to_hex(data[7:4]);
            2'd1: char_out = nibble_to_hex(data[3:0]);
            2'd2: begin
                if (eol) begin
                    char_out = CHR_CR;
                end else begin
                    char_out = CHR_SP;
                    last     = 1'b1;
                end
            end
            default: begin
                char_out = CHR_LF;
                last     = 1'b1;
            end
        endcase
    end

endmodule : hex_fmt
`default_nettype wire

// File: rtl/mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump
//  Description : Commanded engine that streams a byte range from one of
//                NBANKS byte-wide synchronous RAM banks (1-cycle read
//                latency) into a UART transmitter using tx_start/tx_busy.
//                Output is either raw bytes or an ASCII hex dump with
//                BYTES_PER_LINE bytes per line, every line ended by CR LF.
//  Ports       : CLK, RST_N      - clock, synchronous active-low reset
//                start           - command strobe (accepted only when idle)
//                bank_sel, base_addr, length, hex_mode - command fields
//                busy, done, err - command status
//                mem_addr, mem_re, mem_rdata - shared RAM read port
//                tx_start, tx_char, tx_busy  - UART transmitter handshake
//  Revision    : 1.0  initial release
// ============================================================================
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter  int AW             = 15,
    parameter  int NBANKS         = 2,
    parameter  int BYTES_PER_LINE = 16,
    localparam int BW             = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [BW-1:0]       bank_sel,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         length,
    input  logic                hex_mode,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_re,
    input  logic [NBANKS*8-1:0] mem_rdata,
    output logic                tx_start,
    output logic [7:0]          tx_char,
    input  logic                tx_busy
);

    // Column counter width; a 1-byte line still needs one bit.
    localparam int CW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam logic [CW-1:0] c_last_col = CW'(BYTES_PER_LINE - 1);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    dump_state_t   r_state,    w_state_nxt;
    logic [BW-1:0] r_bank,     w_bank_nxt;
    logic [AW-1:0] r_base,     w_base_nxt;
    logic [AW:0]   r_len,      w_len_nxt;
    logic          r_hex,      w_hex_nxt;
    logic [AW:0]   r_idx,      w_idx_nxt;
    logic [CW-1:0] r_col,      w_col_nxt;
    logic [1:0]    r_cidx,     w_cidx_nxt;
    logic [7:0]    r_byte,     w_byte_nxt;
    logic          r_busy,     w_busy_nxt;
    logic          r_done,     w_done_nxt;
    logic          r_err,      w_err_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic          r_mem_re,   w_mem_re_nxt;
    logic          r_tx_start, w_tx_start_nxt;
    logic [7:0]    r_tx_char,  w_tx_char_nxt;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [7:0]  w_rdata;
    logic [AW:0] w_idx_inc;
    logic        w_eol;
    logic        w_bank_bad;
    logic [7:0]  w_fmt_char;
    logic        w_fmt_last;
    logic [7:0]  w_char;
    logic        w_last;

    // Bank slice of the shared read bus, chosen by the latched bank.
    always_comb begin
        w_rdata = 8'h00;
        for (int k = 0; k < NBANKS; k++) begin
            if (r_bank == BW'(k)) begin
                w_rdata = mem_rdata[8*k +: 8];
            end
        end
    end

    assign w_idx_inc  = r_idx + 1'b1;
    // A byte closes its line when the line is full or it is the last byte.
    assign w_eol      = (r_col == c_last_col) || (w_idx_inc == r_len);
    // Widened compare so the check still works when NBANKS == 2**BW.
    assign w_bank_bad = ({1'b0, bank_sel} >= (BW+1)'(NBANKS));

    hex_fmt u_hex_fmt (
        .data     (r_byte),
        .char_idx (r_cidx),
        .eol      (w_eol),
        .char_out (w_fmt_char),
        .last     (w_fmt_last)
    );

    // Raw mode sends the byte itself as its only character.
    assign w_char = r_hex ? w_fmt_char : r_byte;
    assign w_last = r_hex ? w_fmt_last : 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_bank     <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_hex      <= 1'b0;
            r_idx      <= '0;
            r_col      <= '0;
            r_cidx     <= '0;
            r_byte     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_re   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_char  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bank     <= w_bank_nxt;
            r_base     <= w_base_nxt;
            r_len      <= w_len_nxt;
            r_hex      <= w_hex_nxt;
            r_idx      <= w_idx_nxt;
            r_col      <= w_col_nxt;
            r_cidx     <= w_cidx_nxt;
            r_byte     <= w_byte_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_re   <= w_mem_re_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_char  <= w_tx_char_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead so that every port is driven straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_bank_nxt     = r_bank;
        w_base_nxt     = r_base;
        w_len_nxt      = r_len;
        w_hex_nxt      = r_hex;
        w_idx_nxt      = r_idx;
        w_col_nxt      = r_col;
        w_cidx_nxt     = r_cidx;
        w_byte_nxt     = r_byte;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_re_nxt   = 1'b0;
        w_tx_start_nxt = 1'b0;
        w_tx_char_nxt  = r_tx_char;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_bank_nxt = bank_sel;
                    w_base_nxt = base_addr;
                    w_len_nxt  = length;
                    w_hex_nxt  = hex_mode;
                    w_idx_nxt  = '0;
                    w_col_nxt  = '0;
                    w_cidx_nxt = '0;
                    if (w_bank_bad) begin
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = FIN;
                    end else if (length == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = FIN;
                    end else begin
                        w_busy_nxt     = 1'b1;
                        w_mem_addr_nxt = base_addr;
                        w_mem_re_nxt   = 1'b1;
                        w_state_nxt    = FETCH;
                    end
                end
            end

            FETCH: begin
                w_state_nxt = LAT;
            end

            LAT: begin
                // RAM data is valid in this cycle; capture on the way out.
                w_byte_nxt  = w_rdata;
                w_state_nxt = EMIT;
            end

            EMIT: begin
                if (!tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_char_nxt  = w_char;
                    w_state_nxt    = ARM;
                end
            end

            ARM: begin
                // tx_busy may not have risen yet in response to tx_start.
                w_state_nxt = TXWAIT;
            end

            TXWAIT: begin
                if (!tx_busy) begin
                    if (!w_last) begin
                        w_cidx_nxt  = r_cidx + 2'd1;
                        w_state_nxt = EMIT;
                    end else begin
                        w_cidx_nxt = '0;
                        w_idx_nxt  = w_idx_inc;
                        w_col_nxt  = w_eol ? '0 : (r_col + CW'(1));
                        if (w_idx_inc == r_len) begin
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = FIN;
                        end else begin
                            // Truncation to AW bits gives the address wrap.
                            w_mem_addr_nxt = r_base + w_idx_inc[AW-1:0];
                            w_mem_re_nxt   = 1'b1;
                            w_state_nxt    = FETCH;
                        end
                    end
                end
            end

            FIN: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign mem_addr = r_mem_addr;
    assign mem_re   = r_mem_re;
    assign tx_start = r_tx_start;
    assign tx_char  = r_tx_char;

endmodule : mem_dump
`default_nettype wire

// File: tb/tb_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_dump
//  Description : Self-checking bench for mem_dump. Provides a banked RAM
//                with one-cycle read latency, a UART stand-in with a random
//                busy time, a monitor that records the observable traffic,
//                and a reference model that derives the expected character
//                and address streams directly from the dump rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_dump;

    localparam int AW     = 6;
    localparam int NBANKS = 3;
    localparam int BPL    = 2;
    localparam int BW     = 2;
    localparam int DEPTH  = 1 << AW;
    localparam int LIMIT  = 20000;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                start;
    logic [BW-1:0]       bank_sel;
    logic [AW-1:0]       base_addr;
    logic [AW:0]         length;
    logic                hex_mode;
    logic                busy, done, err;
    logic [AW-1:0]       mem_addr;
    logic                mem_re;
    logic [NBANKS*8-1:0] mem_rdata;
    logic                tx_start;
    logic [7:0]          tx_char;
    logic                tx_busy;

    always #5 CLK = ~CLK;

    mem_dump #(.AW(AW), .NBANKS(NBANKS), .BYTES_PER_LINE(BPL)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .bank_sel  (bank_sel),
        .base_addr (base_addr),
        .length    (length),
        .hex_mode  (hex_mode),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .tx_start  (tx_start),
        .tx_char   (tx_char),
        .tx_busy   (tx_busy)
    );

    // ---------------- environment: RAM banks and UART ----------------
    logic [7:0] mem [NBANKS][DEPTH];
    int         uart_cnt = 0;

    initial mem_rdata = '0;
    always @(posedge CLK) begin
        if (mem_re) begin
            for (int k = 0; k < NBANKS; k++) mem_rdata[8*k +: 8] <= mem[k][mem_addr];
        end
    end

    always @(posedge CLK) begin
        if (tx_start)          uart_cnt <= $urandom_range(1, 5);
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end
    assign tx_busy = (uart_cnt != 0);

    // ---------------- monitor ----------------
    logic [7:0]    got_c[$];
    logic [AW-1:0] got_a[$];
    int            n_done = 0, n_errp = 0, viol = 0;
    logic          prev_ts = 1'b0, prev_re = 1'b0;

    always @(negedge CLK) begin
        if (tx_start) begin
            got_c.push_back(tx_char);
            if (tx_busy || prev_ts) viol++;
        end
        if (mem_re) begin
            got_a.push_back(mem_addr);
            if (prev_re) viol++;
        end
        if (done) n_done++;
        if (err) begin
            n_errp++;
            if (!done) viol++;
        end
        if (busy && done) viol++;
        prev_ts = tx_start;
        prev_re = mem_re;
    end

    // ---------------- checking ----------------
    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    task automatic clear_mon();
        got_c.delete();
        got_a.delete();
        n_done = 0;
        n_errp = 0;
        viol   = 0;
    endtask

    // Issue one command and compare everything it produced against the model.
    task automatic run_cmd(input int b, input int base, input int len,
                           input bit hx, input bit poke, input string nm);
        logic [7:0]    exp_c[$];
        logic [AW-1:0] exp_a[$];
        bit            quick;
        int            cyc;
        quick = (b >= NBANKS) || (len == 0);
        if (b < NBANKS) begin
            for (int i = 0; i < len; i++) begin
                int a;
                int d;
                a = (base + i) % DEPTH;
                exp_a.push_back(AW'(a));
                d = mem[b][a];
                if (hx) begin
                    exp_c.push_back(hexc(d / 16));
                    exp_c.push_back(hexc(d % 16));
                    if (((i + 1) % BPL == 0) || (i == len - 1)) begin
                        exp_c.push_back(8'h0D);
                        exp_c.push_back(8'h0A);
                    end else begin
                        exp_c.push_back(8'h20);
                    end
                end else begin
                    exp_c.push_back(8'(d));
                end
            end
        end

        @(negedge CLK);
        clear_mon();
        start     = 1'b1;
        bank_sel  = BW'(b);
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        hex_mode  = hx;
        @(negedge CLK);
        start = 1'b0;
        check({nm, ".busy1"}, busy, quick ? 1'b0 : 1'b1);
        check({nm, ".done1"}, done, quick ? 1'b1 : 1'b0);

        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge CLK);
            cyc++;
            if (poke && cyc == 6) begin
                start     = 1'b1;
                bank_sel  = '0;
                base_addr = '0;
                length    = 7'd1;
                hex_mode  = ~hx;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({nm, ".finished"}, done, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        check({nm, ".ndone"}, n_done, 1);
        check({nm, ".nerr"}, n_errp, (b >= NBANKS) ? 1 : 0);
        check({nm, ".proto"}, viol, 0);
        check({nm, ".busy_end"}, busy, 1'b0);
        check({nm, ".nchars"}, got_c.size(), exp_c.size());
        check({nm, ".naddr"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++)
            check($sformatf("%s.char%0d", nm, i), got_c[i], exp_c[i]);
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
            check($sformatf("%s.addr%0d", nm, i), got_a[i], exp_a[i]);
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, ".busy"}, busy, 1'b0);
        check({nm, ".done"}, done, 1'b0);
        check({nm, ".err"}, err, 1'b0);
        check({nm, ".mem_re"}, mem_re, 1'b0);
        check({nm, ".mem_addr"}, mem_addr, '0);
        check({nm, ".tx_start"}, tx_start, 1'b0);
        check({nm, ".tx_char"}, tx_char, 8'h00);
    endtask

    initial begin
        int cyc;
        RST_N     = 1'b0;
        start     = 1'b0;
        bank_sel  = '0;
        base_addr = '0;
        length    = '0;
        hex_mode  = 1'b0;
        for (int k = 0; k < NBANKS; k++)
            for (int a = 0; a < DEPTH; a++) mem[k][a] = 8'($urandom);
        for (int a = 0; a < 4; a++) mem[1][a] = 8'(8'h41 + a);
        mem[0][0] = 8'h00;
        mem[0][1] = 8'hAB;
        mem[0][2] = 8'h7F;

        // Reset and idle
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_reset_outs("reset");
        clear_mon();
        repeat (10) @(negedge CLK);
        check("idle.ndone", n_done, 0);
        check("idle.nchars", got_c.size(), 0);
        check("idle.busy", busy, 1'b0);

        // Directed commands
        run_cmd(1, 0, 4, 1'b0, 1'b0, "raw");
        run_cmd(0, 0, 3, 1'b1, 1'b0, "hex");
        run_cmd(2, DEPTH - 2, 4, 1'b0, 1'b0, "wrap");
        run_cmd(0, 5, 0, 1'b1, 1'b0, "len0");
        run_cmd(NBANKS, 5, 3, 1'b0, 1'b0, "badbank");
        run_cmd(2, 20, 6, 1'b1, 1'b1, "poke");

        // Reset during TXWAIT of the second byte
        @(negedge CLK);
        clear_mon();
        start     = 1'b1;
        bank_sel  = 2'd1;
        base_addr = 6'd10;
        length    = 7'd5;
        hex_mode  = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        cyc = 0;
        while (!(got_c.size() == 2 && tx_busy) && cyc < LIMIT) begin
            @(negedge CLK);
            cyc++;
        end
        check("rstmid.reached", (got_c.size() == 2 && tx_busy) ? 1 : 0, 1);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check_reset_outs("rstmid");
        repeat (5) @(negedge CLK);
        check("rstmid.ndone", n_done, 0);
        check("rstmid.nchars", got_c.size(), 2);
        run_cmd(1, 10, 5, 1'b1, 1'b0, "after_rst");

        // Whole bank in one command
        run_cmd(0, 17, DEPTH, 1'b0, 1'b0, "fullbank");

        // Random commands
        for (int t = 0; t < 8; t++) begin
            run_cmd($urandom_range(0, NBANKS - 1), $urandom_range(0, DEPTH - 1),
                    $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b0,
                    $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_dump
`default_nettype wire
